// File: rtl/usb_system_sw_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch-scan controller.
interface usb_system_sw_scan_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/usb_system_sw_scan_ctrl.sv
// Switch-scan controller: 2-flop sync, tick-sampled 3-deep debounce,
// selectable edge capture (W1C) and masked level interrupt on Avalon-MM.

// One switch lane: synchronizer, debounce history, debounced state,
// edge detector and its sticky capture bit.
module usb_system_sw_scan_ctrl_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_i,
  input  logic       tick_i,
  input  logic       deb_en_i,
  input  logic       ctrl_wr_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       deb_o,
  output logic       cap_o
);
  logic       s1_q, s2_q;
  logic [2:0] hist_q, hist_d;   // bit0 = h0 (newest), bit2 = h2 (oldest)
  logic       deb_q, deb_d;
  logic       prev_q;
  logic       cap_q, cap_d;
  logic       rise, fall, set;

  // History shifts on tick; a CONTROL write re-seeds it with the current
  // debounced value so a mode change cannot fake a transition.
  always_comb begin
    hist_d = hist_q;
    if (ctrl_wr_i)
      hist_d = {3{deb_q}};
    else if (tick_i)
      hist_d = {hist_q[1:0], s2_q};
  end

  // Debounced state: follow s2 in bypass, else only on 3 agreeing samples.
  always_comb begin
    deb_d = deb_q;
    if (!deb_en_i)
      deb_d = s2_q;
    else if (hist_q == 3'b111)
      deb_d = 1'b1;
    else if (hist_q == 3'b000)
      deb_d = 1'b0;
  end

  assign rise = deb_q & ~prev_q;
  assign fall = ~deb_q & prev_q;

  // Edge selection and sticky capture; a new edge beats a same-cycle clear.
  always_comb begin
    set = 1'b0;
    case (mode_i)
      2'b00:   set = rise;
      2'b01:   set = fall;
      2'b10:   set = rise | fall;
      default: set = 1'b0;
    endcase
    cap_d = (cap_q & ~clr_i) | set;
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 3'b000;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      hist_q <= hist_d;
      deb_q  <= deb_d;
      prev_q <= deb_q;
      cap_q  <= cap_d;
    end
  end

  assign deb_o = deb_q;
  assign cap_o = cap_q;
endmodule

module usb_system_sw_scan_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  usb_system_sw_scan_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]         in_port
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  logic             wr_en, ctrl_wr, mask_wr, cap_wr;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] deb, cap;
  logic [31:0]      rd_q, rd_d;
  logic             unused_wd;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign mask_wr = wr_en && (bus.address == 2'd1);
  assign cap_wr  = wr_en && (bus.address == 2'd2);
  assign ctrl_wr = wr_en && (bus.address == 2'd3);
  assign clr     = cap_wr ? bus.writedata[WIDTH-1:0] : '0;
  assign tick    = (cnt_q == CNT_MAX);
  assign unused_wd = ^bus.writedata;

  // Prescaler: free-running modulo TICK_DIV, re-phased by a CONTROL write.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (ctrl_wr || tick)
      cnt_d = '0;
  end

  // Software-visible control and mask registers.
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    if (ctrl_wr) ctrl_d = bus.writedata[2:0];
    if (mask_wr) mask_d = bus.writedata[WIDTH-1:0];
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      usb_system_sw_scan_ctrl_lane u_lane (
        .clk       (clk),
        .reset     (reset),
        .in_i      (in_port[g]),
        .tick_i    (tick),
        .deb_en_i  (ctrl_q[0]),
        .ctrl_wr_i (ctrl_wr),
        .mode_i    (ctrl_q[2:1]),
        .clr_i     (clr[g]),
        .deb_o     (deb[g]),
        .cap_o     (cap[g])
      );
    end
  endgenerate

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_d = '0;
    case (bus.address)
      2'd0:    rd_d[WIDTH-1:0] = deb;
      2'd1:    rd_d[WIDTH-1:0] = mask_q;
      2'd2:    rd_d[WIDTH-1:0] = cap;
      default: rd_d[2:0]       = ctrl_q;
    endcase
  end

  // Top-level registers: prescaler, control, mask and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      ctrl_q <= 3'b001;
      mask_q <= '0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ctrl_q <= ctrl_d;
      mask_q <= mask_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = |(cap & mask_q);
endmodule

// File: tb/tb_usb_system_sw_scan_ctrl.sv
// Bench for usb_system_sw_scan_ctrl: directed scenarios plus randomized
// traffic against a sample-run-length reference model.
module tb_usb_system_sw_scan_ctrl;
  localparam int W  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  int           errors = 0;
  int           checks = 0;

  usb_system_sw_scan_ctrl_if bus_if ();

  usb_system_sw_scan_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Debounce is modelled as "value of the latest tick sample and how many
  // consecutive ticks agreed with it"; 3 agreeing samples make it stable.
  logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_cap, m_mask, m_last, m_sel;
  logic [2:0]   m_ctrl;
  logic [31:0]  m_rd;
  int           m_phase;
  int           m_run [W];
  logic         m_irq;
  logic         m_wr, m_tick;

  assign m_wr   = bus_if.chipselect && !bus_if.write_n;
  assign m_tick = (m_phase == TD - 1);
  assign m_irq  = |(m_cap & m_mask);

  always_comb begin
    m_sel = '0;
    case (m_ctrl[2:1])
      2'b00: m_sel = m_deb & ~m_prev;
      2'b01: m_sel = ~m_deb & m_prev;
      2'b10: m_sel = m_deb ^ m_prev;
      default: m_sel = '0;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_deb <= '0; m_prev <= '0; m_cap <= '0;
      m_mask <= '0; m_last <= '0; m_ctrl <= 3'b001; m_rd <= '0; m_phase <= 0;
      for (int i = 0; i < W; i++) m_run[i] <= 3;
    end else begin
      m_s1 <= in_port;
      m_s2 <= m_s1;
      m_phase <= (m_wr && bus_if.address == 2'd3) ? 0 : (m_phase + 1) % TD;
      for (int i = 0; i < W; i++) begin
        if (m_wr && bus_if.address == 2'd3) begin
          m_last[i] <= m_deb[i];
          m_run[i]  <= 3;
        end else if (m_tick) begin
          if (m_s2[i] == m_last[i]) m_run[i] <= (m_run[i] >= 3) ? 3 : m_run[i] + 1;
          else begin
            m_last[i] <= m_s2[i];
            m_run[i]  <= 1;
          end
        end
        if (!m_ctrl[0]) m_deb[i] <= m_s2[i];
        else if (m_run[i] >= 3) m_deb[i] <= m_last[i];
      end
      m_prev <= m_deb;
      m_cap  <= (m_cap & ~((m_wr && bus_if.address == 2'd2) ? bus_if.writedata[W-1:0] : '0)) | m_sel;
      if (m_wr && bus_if.address == 2'd1) m_mask <= bus_if.writedata[W-1:0];
      if (m_wr && bus_if.address == 2'd3) m_ctrl <= bus_if.writedata[2:0];
      case (bus_if.address)
        2'd0: m_rd <= {24'd0, m_deb};
        2'd1: m_rd <= {24'd0, m_mask};
        2'd2: m_rd <= {24'd0, m_cap};
        default: m_rd <= {29'd0, m_ctrl};
      endcase
    end
  end

  // ---------------- bus helpers (no checking) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = a; bus_if.writedata = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_port = '0;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h0; exp_v[1] = 32'h0; exp_v[2] = 32'h0; exp_v[3] = 32'h1;
    @(negedge clk);
    reset = 1'b1; bus_if.address = 2'd3;
    @(negedge clk);
    checks++;
    if (bus_if.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h expected %h", bus_if.readdata, 32'h0);
    end
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", bus_if.irq);
    end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== exp_v[a]) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, exp_v[a]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    do_reset();
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h1);
    in_port = 8'h01;                 // changes before edge k
    idle(3);                         // after k+2
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++; $display("FAIL bypass_irq_early: got %b expected 0", bus_if.irq);
    end
    idle(1);                         // after k+3
    checks++;
    if (bus_if.irq !== 1'b1) begin
      errors++; $display("FAIL bypass_irq_k3: got %b expected 1", bus_if.irq);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL bypass_edgecap: got %h expected %h", d, 32'h01);
    end
    bus_write(2'd2, 32'h1);
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++; $display("FAIL bypass_w1c_irq: got %b expected 0", bus_if.irq);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    int n;
    do_reset();
    bus_write(2'd3, 32'h1);
    in_port = 8'h08;
    idle(2);
    in_port = 8'h00;
    idle(20);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL glitch_data: got %h expected %h", d, 32'h0);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL glitch_edgecap: got %h expected %h", d, 32'h0);
    end
    bus_if.address = 2'd0;
    in_port = 8'h08;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.readdata !== 32'h08 && n < 18);
    checks++;
    if (bus_if.readdata !== 32'h08 || n < 12) begin
      errors++; $display("FAIL deb_latency: got %h after %0d cycles expected %h within 12..17", bus_if.readdata, n, 32'h08);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h08) begin
      errors++; $display("FAIL deb_edgecap: got %h expected %h", d, 32'h08);
    end
  endtask

  task automatic test_mode_both();
    logic [31:0] d;
    do_reset();
    bus_write(2'd3, 32'h4);
    in_port = 8'h01; idle(6);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL both_rise: got %h expected %h", d, 32'h01);
    end
    bus_write(2'd2, 32'h1);
    in_port = 8'h00; idle(6);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h01) begin
      errors++; $display("FAIL both_fall: got %h expected %h", d, 32'h01);
    end
  endtask

  task automatic test_mode_none();
    logic [31:0] d;
    do_reset();
    bus_write(2'd3, 32'h6);
    in_port = 8'h01; idle(6);
    in_port = 8'h00; idle(6);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL none_edgecap: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    bus_write(2'd3, 32'h0);
    in_port = 8'h01; idle(6);       // pre-load bit0 so the clear has work to do
    in_port = 8'h05;                // new bit-2 edge before edge k
    idle(2);                        // after k+1
    @(negedge clk);                 // after k+2: arm write for edge k+3
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = 2'd2; bus_if.writedata = 32'hFF;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h04) begin
      errors++; $display("FAIL set_beats_clr: got %h expected %h", d, 32'h04);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h0; exp_v[1] = 32'h0; exp_v[2] = 32'h0; exp_v[3] = 32'h1;
    do_reset();
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h3);         // debounce, falling edges
    in_port = 8'h20; idle(7);
    do_reset();
    idle(20);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      checks++;
      if (d !== exp_v[a]) begin
        errors++; $display("FAIL midreset_reg%0d: got %h expected %h", a, d, exp_v[a]);
      end
    end
    checks++;
    if (bus_if.irq !== 1'b0) begin
      errors++; $display("FAIL midreset_irq: got %b expected 0", bus_if.irq);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      checks++;
      if (bus_if.readdata !== m_rd) begin
        errors++; $display("FAIL rand_rd cyc %0d: got %h expected %h", c, bus_if.readdata, m_rd);
      end
      checks++;
      if (bus_if.irq !== m_irq) begin
        errors++; $display("FAIL rand_irq cyc %0d: got %b expected %b", c, bus_if.irq, m_irq);
      end
      if ($urandom_range(0, 15) == 0)
        in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      bus_if.address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.writedata = $urandom;
      end else begin
        bus_if.chipselect = $urandom_range(0, 1) == 1;
        bus_if.write_n = 1'b1;
        bus_if.writedata = $urandom;
      end
      @(negedge clk);
    end
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  initial begin
    bus_if.address = '0; bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1; bus_if.writedata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_bypass();
    test_debounce();
    test_mode_both();
    test_mode_none();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_system_sw_scan_ctrl.md
# usb_system_sw_scan_ctrl

Switch-scan controller for the slide-switch input bank of the USB system. It synchronizes the raw `in_port` lines and debounces them on a programmable sample tick. It detects selected edges into a sticky edge-capture register and raises a maskable interrupt. It sits on the Avalon-MM bus as an enhanced replacement for the plain switch input port, with the same 1-wait-state registered read behaviour and added control, mask and capture registers.

## Interface
- `WIDTH`, 8: number of switch inputs (1..32).
- `TICK_DIV`, 50000: clk cycles per debounce sample tick (≥2); 1 ms at 50 MHz.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock domain.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select; qualifies writes.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  raw asynchronous switch lines.
- `readdata`  out  32  registered read data; unused upper bits are 0.
- `irq`  out  1  level interrupt, high while any masked capture bit is set.

## Operation
- Register map. Reads are always enabled; writes occur when `chipselect=1` and `write_n=0`.
  - Address 0, DATA (RO): debounced state `deb[WIDTH-1:0]`. Writes are ignored.
  - Address 1, IRQMASK (RW): `mask[WIDTH-1:0]`.
  - Address 2, EDGECAP (R/W1C): writing a 1 clears the corresponding bit.
  - Address 3, CONTROL (RW), bits [2:0]:
    - bit0 `deb_en`.
    - bits[2:1] `mode`: 00 rising, 01 falling, 10 both, 11 none.
- Synchronizer: `s1 <= in_port`, `s2 <= s1`, every cycle.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. `tick` is 1 in the cycle where the counter equals TICK_DIV-1.
- Debounce, `deb_en=1`:
  - On `tick`, per-bit history shifts: `h2<=h1`, `h1<=h0`, `h0<=s2`.
  - Each cycle, per bit:
    - `deb<=1` if h0=h1=h2=1.
    - `deb<=0` if h0=h1=h2=0.
    - Otherwise `deb` holds.
- Bypass, `deb_en=0`: `deb <= s2` every cycle. The history registers keep shifting on `tick`.
- Write to CONTROL: the prescaler is forced to 0, and h0/h1/h2 are all loaded with the current `deb`. This prevents spurious debounced transitions on a mode change.
- Edge detect:
  - `prev <= deb` every cycle.
  - rise = deb & ~prev; fall = ~deb & prev.
  - The selected set is rise, fall, rise|fall, or 0 according to `mode`.
- EDGECAP update: `edgecap <= (edgecap & ~clr) | set`.
  - `clr` is writedata[WIDTH-1:0] during an address-2 write, otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- `irq = |(edgecap & mask)`: combinational from registers, no extra latency.
- Read mux: `readdata <= {zero-extend(mux(address))}` every cycle, where mux selects DATA, IRQMASK, EDGECAP or CONTROL.
- Reset values:
  - s1, s2, h0–h2, deb, prev, edgecap, mask: 0.
  - Prescaler: 0.
  - CONTROL: 3'b001 (debounce on, rising).
  - `readdata`: 0. `irq`: 0.
- Switches that are high at reset debounce to 1 and are captured as a rising edge. This is intended: software clears EDGECAP after init.

## Timing
- Read latency: the address presented before edge n appears on `readdata` after edge n (1 wait state).
- Write effect: registers update at the write edge and are visible in `readdata` when the same address is presented on the following cycle.
- Bypass path, input changing before edge k:
  - s1 updates at k, s2 at k+1, `deb` at k+2.
  - EDGECAP bit and `irq` at k+3 (if the bit is masked).
  - DATA readable on `readdata` after k+3 when address 0 is presented at k+3.
- Debounce path:
  - `deb` changes one cycle after the third consecutive tick that samples the new s2 value.
  - Worst case from input change to `deb`: 2 + 3·TICK_DIV + 1 cycles.
- A glitch shorter than one tick period never changes `deb` while `deb_en=1`.
- Reset asserted mid-debounce or mid-capture: all state returns to the reset values at that edge. Capture bits set in the same cycle are lost.

## Test plan
- Reset, then read all 4 addresses -> 0x0, 0x0, 0x0, 0x1; `irq=0`; `readdata=0` during reset.
- Bypass mode (TICK_DIV=4):
  - Write CONTROL=0x0, MASK=0x01; drive in_port 0x00→0x01 before edge k -> `irq` rises after k+3, EDGECAP reads 0x01.
  - W1C write 0x01 -> `irq=0`.
- Debounce mode (TICK_DIV=4, CONTROL=0x1):
  - Pulse bit 3 high for 2 cycles -> DATA stays 0x00.
  - Hold bit 3 high -> DATA=0x08 within 2+12+1 cycles of the change; EDGECAP=0x08.
- Mode both (CONTROL=0x4), toggle bit 0 high then low -> EDGECAP bit0 set on each edge.
- Mode none (CONTROL=0x6), toggle bit 0 -> EDGECAP stays 0x00.
- Simultaneous events:
  - EDGECAP write 0xFF in the same cycle as a new bit-2 edge -> EDGECAP=0x04 afterwards.
  - Assert reset mid-debounce -> all registers return to reset values, no capture.
